// File: rtl/l1_data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with one 32-bit word per line.
// Hits answer combinationally; misses and every store run a DataMemory handshake while holding busy.
module l1_data_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SET_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  store,
    input  logic [1:0]            size,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  hit,
    output logic                  miss,
    output logic                  busy,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [1:0]            mem_size,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    localparam int NUM_SETS  = 1 << SET_WIDTH;
    localparam int TAG_WIDTH = ADDR_WIDTH - SET_WIDTH - 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_SETS-1:0]     valid_q, valid_d;
    logic [TAG_WIDTH-1:0]    tag_q  [NUM_SETS];
    logic [DATA_WIDTH-1:0]   data_q [NUM_SETS];

    logic [SET_WIDTH-1:0]    index;
    logic [TAG_WIDTH-1:0]    addr_tag;
    logic [1:0]              offset;
    logic                    line_hit;
    logic                    req_load;
    logic                    req_store;
    logic [DATA_WIDTH-1:0]   merged;
    logic                    line_we;
    logic [DATA_WIDTH-1:0]   line_wdata;

    assign index    = address[SET_WIDTH+1:2];
    assign addr_tag = address[ADDR_WIDTH-1:SET_WIDTH+2];
    assign offset   = address[1:0];
    assign line_hit = valid_q[index] && (tag_q[index] == addr_tag);

    // Requests are masked while in reset so hit/miss/busy read 0 even if the pipeline holds a request.
    assign req_store = rst_n & store;
    assign req_load  = rst_n & load & ~store;

    // Store data merged into the resident word; byte lane is the offset, half lane is offset[1].
    always_comb begin
        merged = data_q[index];
        case (size)
            2'b00:   merged[{offset, 3'b000} +: 8]     = data_in[7:0];
            2'b01:   merged[{offset[1], 4'b0000} +: 16] = data_in[15:0];
            default: merged = data_in;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d    = state_q;
        valid_d    = valid_q;
        line_we    = 1'b0;
        line_wdata = merged;
        hit        = 1'b0;
        miss       = 1'b0;
        busy       = 1'b0;
        data_out   = data_q[index];
        case (state_q)
            ST_IDLE: begin
                if (req_store) begin
                    hit     = line_hit;
                    busy    = 1'b1;
                    state_d = ST_WRITE;
                end else if (req_load) begin
                    hit = line_hit;
                    if (!line_hit) begin
                        miss    = 1'b1;
                        busy    = 1'b1;
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                busy = 1'b1;
                if (mem_ready) begin
                    busy           = 1'b0;
                    data_out       = mem_rdata;
                    line_we        = 1'b1;
                    line_wdata     = mem_rdata;
                    valid_d[index] = 1'b1;
                    state_d        = ST_IDLE;
                end
            end
            ST_WRITE: begin
                busy = 1'b1;
                if (mem_ready) begin
                    busy    = 1'b0;
                    line_we = line_hit;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_read  = (state_q == ST_FILL);
    assign mem_write = (state_q == ST_WRITE);
    assign mem_addr  = (state_q == ST_WRITE) ? address : {address[ADDR_WIDTH-1:2], 2'b00};
    assign mem_wdata = data_in;
    assign mem_size  = size;

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    // NOTE: tag and data arrays are intentionally not reset; a clear valid bit masks their contents.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_q[index] <= line_wdata;
            tag_q[index]  <= addr_tag;
        end
    end

endmodule
